delay_tick_monitor: RTL and testbench

- Stage directly downstream of the periodic delay counter; consumes its `sig`, `flg` and `err` status lines.
- Locks onto the `sig` pulse train and checks every period is exactly N+1 cycles.
- Checks the status-line invariants and buffers valid ticks as a pending count drained over a req/ack handshake.
- Reports sticky faults for the formal benches to assert against.

---
 rtl/delay_tick_monitor.sv | 132 +++++++++++++
 tb/tb_delay_tick_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_tick_monitor.sv
// Monitors the sig pulse train from the upstream delay counter, checks spacing
// and status-line invariants, and buffers valid ticks for a req/ack consumer.
module delay_tick_monitor #(
  parameter int N     = 20000,
  parameter int CBITS = 15,
  parameter int DEPTH = 4,
  parameter int PW    = 3,
  parameter int IDW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sig,
  input  logic           flg,
  input  logic           err,
  input  logic           ack,
  output logic           req,
  output logic [IDW-1:0] tick_id,
  output logic [PW-1:0]  pend,
  output logic           locked,
  output logic           ovf,
  output logic           fault,
  output logic [1:0]     fault_code
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, FAULT} state_t;

  localparam logic [CBITS-1:0] GAP_LAST   = CBITS'(N);
  localparam logic [PW-1:0]    PEND_MAX   = PW'(DEPTH);
  localparam logic [1:0]       CODE_NONE  = 2'd0;
  localparam logic [1:0]       CODE_SHORT = 2'd1;
  localparam logic [1:0]       CODE_TMO   = 2'd2;
  localparam logic [1:0]       CODE_PROTO = 2'd3;

  state_t           state, state_nxt;
  logic [CBITS-1:0] gcnt, gcnt_nxt;
  logic [1:0]       code_nxt;
  logic             push, pop, proto_bad;

  assign req    = (pend != '0);
  assign locked = (state == RUN);
  assign fault  = (state == FAULT);
  // Pops are suppressed while disabled so tick_id holds across an en drop.
  assign pop    = req && ack && en;

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    code_nxt  = fault_code;
    push      = 1'b0;
    proto_bad = err || (sig == flg);
    if (!en) begin
      state_nxt = IDLE;
      gcnt_nxt  = '0;
      code_nxt  = CODE_NONE;
    end else begin
      case (state)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (proto_bad) begin
            state_nxt = FAULT;
            code_nxt  = CODE_PROTO;
          end else if (sig) begin
            state_nxt = RUN;
            gcnt_nxt  = '0;
            push      = 1'b1;
          end
        end
        RUN: begin
          // Protocol errors outrank the period checks in the same cycle.
          if (proto_bad) begin
            state_nxt = FAULT;
            code_nxt  = CODE_PROTO;
          end else if (sig) begin
            if (gcnt == GAP_LAST) begin
              gcnt_nxt = '0;
              push     = 1'b1;
            end else begin
              state_nxt = FAULT;
              code_nxt  = CODE_SHORT;
            end
          end else if (gcnt == GAP_LAST) begin
            state_nxt = FAULT;
            code_nxt  = CODE_TMO;
          end else begin
            gcnt_nxt = gcnt + 1'b1;
          end
        end
        FAULT: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gcnt       <= '0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nxt;
      gcnt       <= gcnt_nxt;
      fault_code <= code_nxt;
    end
  end

  // A simultaneous push and pop cancels out, so a full buffer never overflows then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      ovf     <= 1'b0;
      tick_id <= '0;
    end else begin
      if (!en) begin
        pend <= '0;
        ovf  <= 1'b0;
      end else if (push && !pop) begin
        if (pend < PEND_MAX) pend <= pend + 1'b1;
        else                 ovf  <= 1'b1;
      end else if (pop && !push) begin
        pend <= pend - 1'b1;
      end
      if (pop) tick_id <= tick_id + 1'b1;
    end
  end

  a_code_iff_fault: assert property (@(posedge clk) disable iff (!rst)
    (fault_code == CODE_NONE) == !fault);
  a_pend_bound: assert property (@(posedge clk) disable iff (!rst)
    pend <= PEND_MAX);

endmodule

// File: tb/tb_delay_tick_monitor.sv
// Bench for delay_tick_monitor: directed table, hand-written corner sequences and
// a randomized stream, all compared against a timestamp-based reference model.
module tb_delay_tick_monitor;

  localparam int N     = 4;
  localparam int CBITS = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 3;
  localparam int IDW   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0, sig = 1'b0, flg = 1'b1, err = 1'b0, ack = 1'b0;
  logic           req, locked, ovf, fault;
  logic [IDW-1:0] tick_id;
  logic [PW-1:0]  pend;
  logic [1:0]     fault_code;

  delay_tick_monitor #(.N(N), .CBITS(CBITS), .DEPTH(DEPTH), .PW(PW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .sig(sig), .flg(flg), .err(err), .ack(ack),
    .req(req), .tick_id(tick_id), .pend(pend), .locked(locked), .ovf(ovf),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  // Reference model: sig spacing judged from cycle timestamps, buffer as a plain count.
  bit m_active, m_synced, m_faulted, m_ovf;
  int m_code, m_pend, m_ids, m_last, m_cyc;

  typedef struct {
    bit en, sig, flg, err, ack;
    int pend;
    bit locked, fault;
    int code, tid;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(bit e, bit s, bit f, bit x, bit a, int p, bit l, bit ft, int c, int t);
    vec_t v;
    v.en = e; v.sig = s; v.flg = f; v.err = x; v.ack = a;
    v.pend = p; v.locked = l; v.fault = ft; v.code = c; v.tid = t;
    return v;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_synced = 0; m_faulted = 0; m_ovf = 0;
    m_code = 0; m_pend = 0; m_ids = 0; m_last = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    bit pop, push, bad;
    int gap;
    pop  = (m_pend != 0) && ack && en;
    push = 0;
    m_cyc++;
    if (!en) begin
      m_active = 0; m_synced = 0; m_faulted = 0;
      m_pend = 0; m_ovf = 0; m_code = 0;
      return;
    end
    if (!m_active) begin
      m_active = 1;
    end else if (!m_faulted) begin
      bad = err || (sig == flg);
      if (bad) begin
        m_faulted = 1; m_code = 3;
      end else if (!m_synced) begin
        if (sig) begin
          m_synced = 1; m_last = m_cyc; push = 1;
        end
      end else begin
        gap = m_cyc - m_last;
        if (sig && gap == N + 1) begin
          push = 1; m_last = m_cyc;
        end else if (sig) begin
          m_faulted = 1; m_code = 1;
        end else if (gap == N + 1) begin
          m_faulted = 1; m_code = 2;
        end
      end
    end
    if (push && !pop) begin
      if (m_pend < DEPTH) m_pend++;
      else                m_ovf = 1;
    end else if (pop && !push) begin
      m_pend--;
    end
    if (pop) m_ids = (m_ids + 1) % (1 << IDW);
  endtask

  task automatic check_output();
    check_val("pend", int'(pend), m_pend);
    check_val("req", int'(req), int'(m_pend != 0));
    check_val("tick_id", int'(tick_id), m_ids);
    check_val("locked", int'(locked), int'(m_synced && !m_faulted));
    check_val("fault", int'(fault), int'(m_faulted));
    check_val("fault_code", int'(fault_code), m_code);
    check_val("ovf", int'(ovf), int'(m_ovf));
  endtask

  task automatic apply_stimulus(input bit e, input bit s, input bit f, input bit x, input bit a);
    en = e; sig = s; flg = f; err = x; ack = a;
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic stream(input int n, input bit a);
    bit s;
    for (int i = 0; i < n; i++) begin
      s = (phase == 0);
      apply_stimulus(1'b1, s, !s, 1'b0, a);
      phase = (phase + 1) % (N + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; sig = 1'b0; flg = 1'b1; err = 1'b0; ack = 1'b0;
    model_reset();
    phase = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_output();
  endtask

  initial begin
    int ack_pct;
    bit e, s, f, x, a;

    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 1);
    tbl[8]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 2);
    tbl[9]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 2);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 2);
    tbl[11] = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 2);

    do_reset();
    check_val("reset_locked", int'(locked), 0);
    check_val("reset_req", int'(req), 0);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].en, tbl[i].sig, tbl[i].flg, tbl[i].err, tbl[i].ack);
      check_val($sformatf("vec%0d_pend", i), int'(pend), tbl[i].pend);
      check_val($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].locked));
      check_val($sformatf("vec%0d_fault", i), int'(fault), int'(tbl[i].fault));
      check_val($sformatf("vec%0d_code", i), int'(fault_code), tbl[i].code);
      check_val($sformatf("vec%0d_tid", i), int'(tick_id), tbl[i].tid);
    end

    // Ideal stream with ack always high: six ticks, each drained immediately.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 1);
    stream(30, 1);
    check_val("ideal_tid", int'(tick_id), 6);
    check_val("ideal_pend", int'(pend), 0);
    check_val("ideal_fault", int'(fault), 0);

    // Saturation with ack low, then drain.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    stream(26, 0);
    check_val("sat_pend", int'(pend), DEPTH);
    check_val("sat_ovf", int'(ovf), 1);
    stream(4, 1);
    check_val("drain_pend", int'(pend), 0);
    check_val("drain_tid", int'(tick_id), 4);
    check_val("drain_ovf", int'(ovf), 1);

    // Short period, then disable.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    check_val("short_fault", int'(fault), 1);
    check_val("short_code", int'(fault_code), 1);
    check_val("short_pend", int'(pend), 1);
    phase = 1;
    stream(10, 0);
    check_val("short_hold_code", int'(fault_code), 1);
    check_val("short_hold_pend", int'(pend), 1);
    apply_stimulus(0, 0, 1, 0, 0);
    check_val("dis_code", int'(fault_code), 0);
    check_val("dis_fault", int'(fault), 0);
    check_val("dis_locked", int'(locked), 0);

    // Missed pulse timeout.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 1, 0, 0);
    check_val("tmo_not_yet", int'(fault), 0);
    apply_stimulus(1, 0, 1, 0, 0);
    check_val("tmo_fault", int'(fault), 1);
    check_val("tmo_code", int'(fault_code), 2);

    // Protocol error outranks a short period in the same cycle.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0);
    check_val("proto_code", int'(fault_code), 3);
    check_val("proto_pend", int'(pend), 1);

    // Asynchronous reset mid-cycle with ticks pending.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    stream(16, 0);
    stream(1, 1);
    check_val("pre_rst_pend", int'(pend), 3);
    check_val("pre_rst_tid", int'(tick_id), 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_pend", int'(pend), 0);
    check_val("arst_req", int'(req), 0);
    check_val("arst_locked", int'(locked), 0);
    check_val("arst_tid", int'(tick_id), 0);
    model_reset();
    phase = 0;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Push and pop together while full.
    do_reset();
    apply_stimulus(1, 0, 1, 0, 0);
    stream(16, 0);
    stream(4, 0);
    check_val("full_pend", int'(pend), DEPTH);
    stream(1, 1);
    check_val("pp_pend", int'(pend), DEPTH);
    check_val("pp_ovf", int'(ovf), 0);
    check_val("pp_tid", int'(tick_id), 1);

    // Randomized stream with occasional glitches, disables and varying ack density.
    do_reset();
    ack_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) ack_pct = $urandom_range(0, 100);
      e = ($urandom_range(0, 99) != 0);
      s = (phase == 0);
      if ($urandom_range(0, 59) == 0) s = !s;
      f = !s;
      if ($urandom_range(0, 149) == 0) f = s;
      x = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 99) < ack_pct);
      apply_stimulus(e, s, f, x, a);
      phase = (phase + 1) % (N + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
